// File: rtl/axi_ddr_rd_burst_ctrl.sv
// Read-stream controller: paces fixed-length AXI read bursts over an address window,
// buffers beats in a show-ahead FIFO and splits each DDR word into OUT_DW slices.
module axi_ddr_rd_burst_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int DDR_DW     = 128,
  parameter int OUT_DW     = 8,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rd_enable,
  input  logic [ADDR_W-1:0]               rd_addr_begin,
  input  logic [ADDR_W-1:0]               rd_addr_end,
  output logic [OUT_DW-1:0]               out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            rd_start,
  output logic [ADDR_W-1:0]               rd_addr,
  output logic [7:0]                      rd_len,
  input  logic [DDR_DW-1:0]               rd_data,
  input  logic                            rd_vld,
  input  logic                            rd_done,
  input  logic                            rd_busy,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            err_overflow
);

  localparam int SLICES = DDR_DW / OUT_DW;
  localparam int SL_W   = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * DDR_DW / 8);
  localparam logic [LVL_W-1:0]  DEPTH_L     = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0]  BURST_L     = LVL_W'(BURST_LEN);
  localparam logic [8:0]        LEN9        = 9'(BURST_LEN);
  localparam logic [SL_W-1:0]   LAST_SL     = SL_W'(SLICES - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_STOP, S_FLUSH} state_t;

  state_t            state_q, state_d;
  logic              en_q;
  logic [ADDR_W-1:0] win_beg_q, win_beg_d, win_end_q, win_end_d;
  logic [ADDR_W-1:0] addr_q, addr_d, next_addr;
  logic              start_q, start_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [SL_W-1:0]   slice_q, slice_d;
  logic              ovf_q, ovf_d;
  logic              full, vld_out, accept, last_sl, push, pop, rise;
  logic [DDR_DW-1:0] mem [FIFO_DEPTH];
  logic [DDR_DW-1:0] head;

  always_comb begin
    rise      = rd_enable & ~en_q;
    full      = (level_q == DEPTH_L);
    vld_out   = (level_q != '0) && (state_q != S_IDLE) && (state_q != S_FLUSH);
    last_sl   = (slice_q == LAST_SL);
    accept    = vld_out && out_ready;
    pop       = accept && last_sl;
    // Beats are only accepted while a burst we still want is in flight.
    push      = (state_q == S_WAIT) && rd_vld && !full;
    next_addr = addr_q + BURST_BYTES;

    state_d   = state_q;
    win_beg_d = win_beg_q;
    win_end_d = win_end_q;
    addr_d    = addr_q;
    start_d   = 1'b0;
    ovf_d     = ovf_q | ((state_q == S_WAIT) && rd_vld && full);
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d   = level_q + {{(LVL_W-1){1'b0}}, push} - {{(LVL_W-1){1'b0}}, pop};
    slice_d   = accept ? (last_sl ? '0 : slice_q + 1'b1) : slice_q;

    case (state_q)
      S_IDLE: if (rise) begin
        win_beg_d = rd_addr_begin;
        win_end_d = rd_addr_end;
        addr_d    = rd_addr_begin;
        state_d   = S_REQ;
      end
      S_REQ: begin
        if (!rd_enable) state_d = S_FLUSH;
        else if (!rd_busy && (DEPTH_L - level_q) >= BURST_L) begin
          start_d = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rd_done) begin
          addr_d  = (next_addr >= win_end_q) ? win_beg_q : next_addr;
          state_d = rd_enable ? S_REQ : S_FLUSH;
        end else if (!rd_enable) begin
          state_d = S_STOP;
        end
      end
      S_STOP: if (rd_done) state_d = S_FLUSH;
      S_FLUSH: begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        level_d  = '0;
        slice_d  = '0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      en_q      <= 1'b0;
      win_beg_q <= '0;
      win_end_q <= '0;
      addr_q    <= '0;
      start_q   <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      slice_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= rd_enable;
      win_beg_q <= win_beg_d;
      win_end_q <= win_end_d;
      addr_q    <= addr_d;
      start_q   <= start_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      slice_q   <= slice_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= rd_data;
  end

  // Show-ahead head word; output forced to zero when nothing is offered.
  assign head         = mem[rd_ptr_q];
  assign out_data     = vld_out ? head[int'(slice_q)*OUT_DW +: OUT_DW] : '0;
  assign out_valid    = vld_out;
  assign rd_start     = start_q;
  assign rd_addr      = addr_q;
  assign rd_len       = LEN9[7:0];
  assign fifo_level   = level_q;
  assign err_overflow = ovf_q;

endmodule

// File: tb/tb_axi_ddr_rd_burst_ctrl.sv
// Randomized bench: memory-backed AXI master model plus a byte-stream scoreboard
// derived from the window/credit rules.
module tb_axi_ddr_rd_burst_ctrl;
  localparam int AW = 32, DW = 128, OW = 8, BL = 16, FD = 64;
  localparam int BB = BL * DW / 8;

  logic          clk = 1'b0;
  logic          rst, rd_enable, out_ready;
  logic [AW-1:0] rd_addr_begin, rd_addr_end, rd_addr;
  logic [OW-1:0] out_data;
  logic          out_valid, rd_start, err_overflow;
  logic [7:0]    rd_len;
  logic [DW-1:0] rd_data;
  logic          rd_vld, rd_done, rd_busy;
  logic [6:0]    fifo_level;

  axi_ddr_rd_burst_ctrl dut (
    .clk(clk), .rst(rst), .rd_enable(rd_enable),
    .rd_addr_begin(rd_addr_begin), .rd_addr_end(rd_addr_end),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .rd_start(rd_start), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_data(rd_data), .rd_vld(rd_vld), .rd_done(rd_done), .rd_busy(rd_busy),
    .fifo_level(fifo_level), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  // Master controls, written only by the main process.
  int nbeats = BL, hold_at = -1;
  bit abort = 1'b0, stray_req = 1'b0;
  int beat_cnt = 0;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ {a[3:0], a[7:4]} ^ 8'h3C;
  endfunction

  function automatic logic [DW-1:0] beat_data(input logic [31:0] a);
    logic [DW-1:0] d;
    for (int k = 0; k < DW/8; k++) d[k*8 +: 8] = mem_byte(a + 32'(k));
    return d;
  endfunction

  task automatic burst(input logic [31:0] a);
    int i; bit co, held, v;
    i = 0; held = 1'b0; co = 1'($urandom_range(0, 1)); rd_busy = 1'b1;
    while (i < nbeats && !abort) begin
      if (i == hold_at && !held) begin
        held = 1'b1; rd_vld = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
      end
      v = ($urandom_range(0, 3) != 0);
      rd_vld  = v;
      rd_data = beat_data(a + 32'(i) * 32'(DW/8));
      if (v) begin i++; beat_cnt++; end
      rd_done = v && (i == nbeats) && co;
      @(posedge clk); #1;
    end
    rd_vld = 1'b0; rd_done = 1'b0;
    if (!abort && !co) begin
      rd_done = 1'b1; @(posedge clk); #1; rd_done = 1'b0;
    end
    rd_busy = 1'b0;
  endtask

  initial begin
    rd_vld = 1'b0; rd_done = 1'b0; rd_busy = 1'b0; rd_data = '0;
    forever begin
      @(posedge clk); #1;
      rd_vld = 1'b0; rd_done = 1'b0;
      if (stray_req) begin
        rd_vld = 1'b1; rd_done = 1'b1; rd_data = {4{$urandom}};
      end else if (rd_start && !abort) begin
        burst(rd_addr);
      end
    end
  end

  // Scoreboard state
  int n_chk = 0, n_pass = 0, n_starts = 0, n_out = 0;
  logic [31:0] m_beg, m_end, exp_addr;
  logic [7:0]  exp_q[$];
  logic [31:0] start_log[$];
  logic [6:0]  lvl_at_start;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic mon();
    if (rd_start) begin
      n_starts++;
      start_log.push_back(rd_addr);
      lvl_at_start = fifo_level;
      chk("rd_addr", rd_addr, exp_addr);
      chk("rd_len", {24'd0, rd_len}, 32'(BL % 256));
      for (int i = 0; i < BB; i++) exp_q.push_back(mem_byte(exp_addr + 32'(i)));
      exp_addr = (exp_addr + 32'(BB) >= m_end) ? m_beg : exp_addr + 32'(BB);
    end
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() != 0) chk("out_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
      else chk("out_unexpected", {31'd0, out_valid}, 32'd0);
    end
  endtask

  task automatic tick();
    @(negedge clk); mon();
    @(posedge clk); #2;
  endtask

  task automatic start_stream(input logic [31:0] b, input logic [31:0] e);
    rd_addr_begin = b; rd_addr_end = e;
    m_beg = b; m_end = e; exp_addr = b;
    exp_q.delete(); start_log.delete();
    n_starts = 0; n_out = 0;
    rd_enable = 1'b1;
    tick();
  endtask

  task automatic stop_stream(input string tag);
    int idle;
    idle = 0;
    rd_enable = 1'b0;
    for (int k = 0; k < 400 && idle < 6; k++) begin
      tick();
      idle = rd_busy ? 0 : idle + 1;
    end
    chk({tag, "_idle_to"}, 32'(idle >= 6), 32'd1);
    chk({tag, "_level0"}, {25'd0, fifo_level}, 32'd0);
    chk({tag, "_valid0"}, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic wait_starts(input int n, input int lim, input string tag);
    for (int k = 0; k < lim && n_starts < n; k++) tick();
    chk(tag, 32'(n_starts >= n), 32'd1);
  endtask

  task automatic wait_beats(input int base, input int n, input string tag);
    for (int k = 0; k < 400 && (beat_cnt - base) < n; k++) tick();
    chk(tag, 32'((beat_cnt - base) >= n), 32'd1);
  endtask

  initial begin
    int base, st;
    rst = 1'b1; rd_enable = 1'b0; out_ready = 1'b0;
    rd_addr_begin = '0; rd_addr_end = '0;
    m_beg = '0; m_end = '0; exp_addr = '0; lvl_at_start = '0;
    repeat (3) tick();
    chk("rst_rd_start", {31'd0, rd_start}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_level", {25'd0, fifo_level}, 32'd0);
    chk("rst_err", {31'd0, err_overflow}, 32'd0);
    chk("rst_rd_addr", rd_addr, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    rst = 1'b0;
    tick();

    // Basic streaming, full-rate consumer
    out_ready = 1'b1;
    start_stream(32'h1000, 32'h1800);
    for (int k = 0; k < 1500 && n_out < 600; k++) tick();
    chk("basic_bytes", 32'(n_out >= 600), 32'd1);
    chk("basic_first", start_log.size() > 1 ? start_log[1] : 32'hFFFF_FFFF, 32'h1100);
    chk("basic_err", {31'd0, err_overflow}, 32'd0);
    stop_stream("basic");

    // Window wrap
    start_stream(32'h0, 32'h200);
    wait_starts(4, 800, "wrap_to");
    for (int i = 0; i < 4; i++)
      chk("wrap_seq", start_log.size() > i ? start_log[i] : 32'hFFFF_FFFF, (i % 2) ? 32'h100 : 32'h0);
    stop_stream("wrap");

    // Backpressure: credit stops requests at a full FIFO
    out_ready = 1'b0;
    start_stream(32'h2000, 32'h4000);
    repeat (300) tick();
    chk("bp_starts", 32'(n_starts), 32'd4);
    chk("bp_level", {25'd0, fifo_level}, 32'(FD));
    out_ready = 1'b1;
    wait_starts(5, 600, "bp_5th_to");
    chk("bp_lvl_at_5th", {25'd0, lvl_at_start}, 32'(FD - BL));
    chk("bp_err", {31'd0, err_overflow}, 32'd0);
    stop_stream("bp");

    // Drop enable mid-burst after 5 beats
    out_ready = 1'b0; hold_at = 5; base = beat_cnt;
    start_stream(32'h3000, 32'h3800);
    wait_beats(base, 5, "drop_beats_to");
    tick();
    rd_enable = 1'b0;
    tick();
    chk("drop_lvl_stop", {25'd0, fifo_level}, 32'd5);
    stop_stream("drop");
    chk("drop_beats_sent", 32'(beat_cnt - base), 32'(BL));
    chk("drop_err", {31'd0, err_overflow}, 32'd0);
    hold_at = -1; out_ready = 1'b1;
    start_stream(32'h5000, 32'h5400);
    wait_starts(1, 200, "restart_to");
    chk("restart_addr", start_log.size() > 0 ? start_log[0] : 32'hFFFF_FFFF, 32'h5000);
    stop_stream("restart");

    // Overflow from a misbehaving master
    out_ready = 1'b0; nbeats = 70;
    start_stream(32'h6000, 32'h7000);
    wait_starts(1, 200, "ovf_start_to");
    for (int k = 0; k < 400 && rd_busy; k++) tick();
    chk("ovf_done_to", {31'd0, rd_busy}, 32'd0);
    chk("ovf_level", {25'd0, fifo_level}, 32'(FD));
    chk("ovf_err", {31'd0, err_overflow}, 32'd1);
    nbeats = BL;
    stop_stream("ovf");
    chk("ovf_err_sticky", {31'd0, err_overflow}, 32'd1);
    out_ready = 1'b1;
    start_stream(32'h6000, 32'h7000);
    for (int k = 0; k < 800 && n_out < BB; k++) tick();
    chk("ovf_post_bytes", 32'(n_out >= BB), 32'd1);
    stop_stream("ovf2");
    chk("ovf_err_sticky2", {31'd0, err_overflow}, 32'd1);

    // Reset mid-burst, then stray master traffic
    start_stream(32'h8000, 32'h9000);
    base = beat_cnt;
    wait_beats(base, 3, "rst_beats_to");
    abort = 1'b1; rst = 1'b1; rd_enable = 1'b0;
    #1;
    chk("arst_rd_start", {31'd0, rd_start}, 32'd0);
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_level", {25'd0, fifo_level}, 32'd0);
    chk("arst_err", {31'd0, err_overflow}, 32'd0);
    chk("arst_rd_addr", rd_addr, 32'd0);
    chk("arst_out_data", {24'd0, out_data}, 32'd0);
    tick(); tick();
    rst = 1'b0; stray_req = 1'b1; st = n_starts;
    repeat (4) tick();
    stray_req = 1'b0; abort = 1'b0;
    repeat (3) tick();
    chk("stray_starts", 32'(n_starts), 32'(st));
    chk("stray_valid", {31'd0, out_valid}, 32'd0);
    chk("stray_level", {25'd0, fifo_level}, 32'd0);
    chk("stray_err", {31'd0, err_overflow}, 32'd0);
    chk("stray_rd_addr", rd_addr, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
